risc_v_mike_wb_arbiter: RTL and testbench
=========================================

# risc_v_mike_wb_arbiter

Write-side front end of the integer register file. Merges single-cycle ALU results and in-order, variable-latency load responses into the register file's single write port. Load destinations are queued at issue time, and a per-register busy mask is published so decode can stall on pending loads. All write-port outputs are registered, so the block sits between execute/memory and the register file write inputs.

## Interface
- `ADDR_W`, 4: register address width; covers 16 registers.
- `DATA_W`, 32: write data width.
- `LQ_DEPTH`, 4: outstanding-load tag queue depth; power of 2, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `alu_wr_valid`  in  1  ALU result present this cycle; no backpressure.
- `alu_wr_addr`  in  ADDR_W  ALU destination register.
- `alu_wr_data`  in  DATA_W  ALU result.
- `ld_req_valid`  in  1  load issue; reserves a destination.
- `ld_req_addr`  in  ADDR_W  load destination register.
- `ld_req_ready`  out  1  tag queue not full.
- `ld_rsp_valid`  in  1  load data returning, in issue order.
- `ld_rsp_data`  in  DATA_W  load data.
- `ld_rsp_ready`  out  1  response accepted this cycle.
- `busy_mask`  out  2**ADDR_W  bit r set while any queued load targets register r.
- `reg_file_write`  out  1  write enable to the register file.
- `reg_file_wr_addr`  out  ADDR_W  write address.
- `reg_file_wr_data`  out  DATA_W  write data.

## Operation
- Load issue:
  - Handshake `ld_req_valid & ld_req_ready` pushes `ld_req_addr` into the tag queue.
  - `ld_req_ready = !full`. It is independent of a same-cycle pop, so there is no issue into a full queue.
- Load response:
  - `ld_rsp_ready = !empty & !alu_wr_valid`. The ALU always owns the port when valid.
  - Handshake `ld_rsp_valid & ld_rsp_ready` pops the head tag and launches a write of `{head_tag, ld_rsp_data}`.
- ALU:
  - `alu_wr_valid` launches a write of `{alu_wr_addr, alu_wr_data}` unconditionally.
- Register 0:
  - Any write to address 0 is dropped: `reg_file_write` stays 0.
  - The queue still pops, and busy bit 0 still clears.
- Busy mask:
  - `busy_mask[r]` is the OR over valid queue entries of (tag == r). It is combinational from queue state.
  - A bit therefore sets the cycle after the issue handshake and clears the cycle after the pop.
  - Two queued loads to the same register keep the bit set until both have popped.
- Simultaneous push and pop in the same cycle are allowed when the queue is neither full nor empty; the count is unchanged.
- Hazards:
  - WAW ordering between ALU and pending loads is decode's responsibility (stall on `busy_mask`).
  - The block does not reorder writes.
- A response while the queue is empty is a protocol error: `ld_rsp_ready = 0` and no write occurs.

## Timing
- Reset values: `reg_file_write = 0`, `reg_file_wr_addr = 0`, `reg_file_wr_data = 0`, `busy_mask = 0`, `ld_req_ready = 1`, `ld_rsp_ready = 0`. Queue pointers and count are 0.
- Write latency is 1 cycle from source accept to `reg_file_write = 1`. The register file reflects the value one further cycle later.
- `reg_file_write` is a one-cycle pulse per accepted write. Back-to-back writes on consecutive cycles are supported.
- Pointers wrap modulo `LQ_DEPTH`. Full/empty is derived from a count of width log2(`LQ_DEPTH`)+1.
- Reset asserted mid-operation:
  - All queued tags are discarded and `busy_mask` clears immediately (asynchronous).
  - A write in flight is lost, with no partial write.
- Throughput: one write per cycle. A load response stalls only on cycles where `alu_wr_valid = 1`.

## Structure
- In `risc_v_mike_pkg`:
  - Reuse the existing register address typedef `t_register_addr` for all address ports and tags.
  - Add a constant `LQ_DEPTH_DEFAULT = 4` and a typedef `t_wb_req` = {addr, data}.
- Sub-module `risc_v_mike_wb_tag_fifo`:
  - Parameterised synchronous FIFO holding `t_register_addr` entries.
  - Exposes full, empty, head, and a per-entry valid/tag view for the busy-mask reduction.
- Top level: priority mux, x0 suppression, the output register stage, and the busy-mask OR-reduction.

## Test plan
- Reset, then an ALU write (addr 5, `0xDEADBEEF`) → next cycle `reg_file_write = 1`, addr 5, data `0xDEADBEEF`. One-cycle pulse; `busy_mask = 0` throughout.
- Issue loads to 3, then 7; respond with `0x11`, then `0x22` → writes are (3, `0x11`) then (7, `0x22`) in order. `busy_mask` goes `0x0008` → `0x0088` → `0x0080` → `0x0000`.
- Same-cycle `alu_wr_valid` (addr 2) and `ld_rsp_valid` with a load to 9 queued → ALU write to 2 first and `ld_rsp_ready = 0`. The load writes 9 on the following cycle.
- Issue 4 loads without responses → `ld_req_ready = 0`, and a fifth `ld_req_valid` is ignored. One pop re-raises ready; a simultaneous push and pop at count 3 keeps count 3.
- Write to register 0 from the ALU and via a load → `reg_file_write` stays 0, the queue pops, and `busy_mask[0]` clears.
- Assert `rst` low asynchronously with 2 loads queued → `busy_mask = 0`, `ld_req_ready = 1`, and `reg_file_write = 0` immediately. A later response is not accepted (`ld_rsp_ready = 0`).

Source files
------------

// File: rtl/risc_v_mike_pkg.sv
// Shared types for the risc_v_mike integer pipeline.
// Pure declarations: no logic, no latency.
// Consumers apply their own flow control.
package risc_v_mike_pkg;

    localparam int REG_ADDR_W       = 4;
    localparam int XLEN             = 32;
    localparam int LQ_DEPTH_DEFAULT = 4;

    // Register-file address; also used as the load destination tag.
    typedef logic [REG_ADDR_W-1:0] t_register_addr;

    // One register-file write request.
    typedef struct packed {
        t_register_addr  addr;
        logic [XLEN-1:0] data;
    } t_wb_req;

endpackage

// File: rtl/risc_v_mike_wb_tag_fifo.sv
// In-order queue of pending load destination tags with a per-entry valid view.
// Latency: push visible at head/entry view the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module risc_v_mike_wb_tag_fifo
    import risc_v_mike_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  t_register_addr    i_push_tag,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output t_register_addr    o_head,
    output logic [DEPTH-1:0]  o_entry_vld,
    output t_register_addr    o_entry_tag [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    t_register_addr   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Tag storage; contents are only meaningful where the entry is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PTR_W-1:0] w_off;
        assign w_off            = PTR_W'(g) - r_rd_ptr;
        assign o_entry_vld[g]   = (CNT_W'(w_off) < r_count);
        assign o_entry_tag[g]   = r_mem[g];
    end

endmodule

// File: rtl/risc_v_mike_wb_arbiter.sv
// Merges ALU results and in-order load responses onto the single register-file write port.
// Latency: 1 cycle from source accept to registered write strobe.
// Backpressure: ALU never stalls; loads stall on ALU cycles; issue stalls when the tag queue is full.
module risc_v_mike_wb_arbiter
    import risc_v_mike_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = XLEN,
    parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_alu_wr_valid,
    input  t_register_addr       i_alu_wr_addr,
    input  logic [DATA_W-1:0]    i_alu_wr_data,
    input  logic                 i_ld_req_valid,
    input  t_register_addr       i_ld_req_addr,
    output logic                 o_ld_req_ready,
    input  logic                 i_ld_rsp_valid,
    input  logic [DATA_W-1:0]    i_ld_rsp_data,
    output logic                 o_ld_rsp_ready,
    output logic [2**ADDR_W-1:0] o_busy_mask,
    output logic                 o_reg_file_write,
    output t_register_addr       o_reg_file_wr_addr,
    output logic [DATA_W-1:0]    o_reg_file_wr_data
);

    logic                 w_full;
    logic                 w_empty;
    t_register_addr       w_head;
    logic [LQ_DEPTH-1:0]  w_entry_vld;
    t_register_addr       w_entry_tag [LQ_DEPTH];

    logic                 w_push;
    logic                 w_pop;
    logic                 w_launch;
    t_register_addr       w_launch_addr;
    logic [DATA_W-1:0]    w_launch_data;
    logic                 w_wr_en;

    logic                 r_write;
    t_register_addr       r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;

    // Issue readiness ignores a same-cycle pop so the queue never overfills.
    assign o_ld_req_ready = ~w_full;
    assign o_ld_rsp_ready = ~w_empty & ~i_alu_wr_valid;
    assign w_push         = i_ld_req_valid & o_ld_req_ready;
    assign w_pop          = i_ld_rsp_valid & o_ld_rsp_ready;

    risc_v_mike_wb_tag_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_tag_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst),
        .i_push      (w_push),
        .i_push_tag  (i_ld_req_addr),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_entry_vld (w_entry_vld),
        .o_entry_tag (w_entry_tag)
    );

    // ALU owns the port whenever it is valid; otherwise an accepted load response.
    always_comb begin
        w_launch      = 1'b0;
        w_launch_addr = '0;
        w_launch_data = '0;
        if (i_alu_wr_valid) begin
            w_launch      = 1'b1;
            w_launch_addr = i_alu_wr_addr;
            w_launch_data = i_alu_wr_data;
        end else if (w_pop) begin
            w_launch      = 1'b1;
            w_launch_addr = w_head;
            w_launch_data = i_ld_rsp_data;
        end
    end

    // x0 is hardwired zero: the source is still consumed but no write is issued.
    assign w_wr_en = w_launch & (w_launch_addr != '0);

    // Output register stage; reset drops any write that was about to land.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_write   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_write <= w_wr_en;
            if (w_launch) begin
                r_wr_addr <= w_launch_addr;
                r_wr_data <= w_launch_data;
            end
        end
    end

    assign o_reg_file_write   = r_write;
    assign o_reg_file_wr_addr = r_wr_addr;
    assign o_reg_file_wr_data = r_wr_data;

    // Busy bit per register: set while any live queue entry targets it.
    always_comb begin
        o_busy_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (w_entry_vld[i]) begin
                o_busy_mask[w_entry_tag[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_risc_v_mike_wb_arbiter.sv
// Self-checking bench for the write-back arbiter with a queue-based reference model.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// Every scenario task performs its own comparisons.
module tb_risc_v_mike_wb_arbiter;

    localparam int LQ = 4;

    logic        clk;
    logic        rst;
    logic        alu_vld;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        req_vld;
    logic [3:0]  req_addr;
    logic        req_rdy;
    logic        rsp_vld;
    logic [31:0] rsp_data;
    logic        rsp_rdy;
    logic [15:0] busy;
    logic        wr;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    risc_v_mike_wb_arbiter #(
        .ADDR_W   (4),
        .DATA_W   (32),
        .LQ_DEPTH (LQ)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_alu_wr_valid     (alu_vld),
        .i_alu_wr_addr      (alu_addr),
        .i_alu_wr_data      (alu_data),
        .i_ld_req_valid     (req_vld),
        .i_ld_req_addr      (req_addr),
        .o_ld_req_ready     (req_rdy),
        .i_ld_rsp_valid     (rsp_vld),
        .i_ld_rsp_data      (rsp_data),
        .o_ld_rsp_ready     (rsp_rdy),
        .o_busy_mask        (busy),
        .o_reg_file_write   (wr),
        .o_reg_file_wr_addr (wr_addr),
        .o_reg_file_wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: pending load tags in issue order plus the expected write.
    int          q[$];
    logic        exp_wr;
    logic [3:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_req_rdy;
    logic        exp_rsp_rdy;
    logic [15:0] exp_busy;
    logic        obs_req_rdy;
    logic        obs_rsp_rdy;
    logic [15:0] obs_busy;

    int n_chk  = 0;
    int n_fail = 0;

    // One clock cycle with current inputs: snapshot handshake outputs, then advance the model.
    task automatic cycle();
        logic rsp_acc;
        logic push;
        #1;
        exp_req_rdy = (q.size() < LQ);
        exp_rsp_rdy = (q.size() > 0) && !alu_vld;
        exp_busy    = '0;
        foreach (q[i]) exp_busy[q[i]] = 1'b1;
        obs_req_rdy = req_rdy;
        obs_rsp_rdy = rsp_rdy;
        obs_busy    = busy;
        @(posedge clk);
        rsp_acc = rsp_vld && (q.size() > 0) && !alu_vld;
        push    = req_vld && (q.size() < LQ);
        if (alu_vld) begin
            exp_wr   = (alu_addr != 0);
            exp_addr = alu_addr;
            exp_data = alu_data;
        end else if (rsp_acc) begin
            exp_wr   = (q[0] != 0);
            exp_addr = 4'(q[0]);
            exp_data = rsp_data;
        end else begin
            exp_wr = 1'b0;
        end
        if (rsp_acc) void'(q.pop_front());
        if (push) q.push_back(int'(req_addr));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_vld = 0; alu_addr = 0; alu_data = 0;
        req_vld = 0; req_addr = 0;
        rsp_vld = 0; rsp_data = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        rsp_vld = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", wr); end
        n_chk++; if (wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", wr_addr); end
        n_chk++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", wr_data); end
        n_chk++; if (busy !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_chk++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_rdy); end
        n_chk++; if (rsp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ready: got %b want 0", rsp_rdy); end
        @(negedge clk);
        rsp_vld = 1'b0;
        rst     = 1'b1;
        q.delete();
        exp_wr  = 1'b0;
    endtask

    task automatic test_alu_write();
        alu_vld = 1; alu_addr = 4'd5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_vld = 0;
        n_chk++; if (wr !== 1'b1) begin n_fail++; $display("FAIL alu_write: got %b want 1", wr); end
        n_chk++; if (wr_addr !== 4'd5) begin n_fail++; $display("FAIL alu_addr: got %h want 5", wr_addr); end
        n_chk++; if (wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data: got %h want deadbeef", wr_data); end
        n_chk++; if (obs_busy !== 16'h0) begin n_fail++; $display("FAIL alu_busy: got %h want 0", obs_busy); end
        cycle();
        n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL alu_pulse: got %b want 0", wr); end
        n_chk++; if (busy !== 16'h0) begin n_fail++; $display("FAIL alu_busy_after: got %h want 0", busy); end
    endtask

    task automatic test_load_order();
        req_vld = 1; req_addr = 4'd3;
        cycle();
        n_chk++; if (busy !== 16'h0008) begin n_fail++; $display("FAIL ld_busy1: got %h want 0008", busy); end
        req_addr = 4'd7;
        cycle();
        n_chk++; if (busy !== 16'h0088) begin n_fail++; $display("FAIL ld_busy2: got %h want 0088", busy); end
        req_vld = 0; rsp_vld = 1; rsp_data = 32'h11;
        cycle();
        n_chk++; if (wr !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 32'h11)
            begin n_fail++; $display("FAIL ld_write1: got %b/%h/%h want 1/3/11", wr, wr_addr, wr_data); end
        n_chk++; if (busy !== 16'h0080) begin n_fail++; $display("FAIL ld_busy3: got %h want 0080", busy); end
        rsp_data = 32'h22;
        cycle();
        n_chk++; if (wr !== 1'b1 || wr_addr !== 4'd7 || wr_data !== 32'h22)
            begin n_fail++; $display("FAIL ld_write2: got %b/%h/%h want 1/7/22", wr, wr_addr, wr_data); end
        n_chk++; if (busy !== 16'h0000) begin n_fail++; $display("FAIL ld_busy4: got %h want 0000", busy); end
        rsp_vld = 0;
        cycle();
        n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL ld_idle: got %b want 0", wr); end
    endtask

    task automatic test_alu_priority();
        req_vld = 1; req_addr = 4'd9;
        cycle();
        req_vld = 0;
        alu_vld = 1; alu_addr = 4'd2; alu_data = 32'hA5A5_0002;
        rsp_vld = 1; rsp_data = 32'h99;
        cycle();
        n_chk++; if (obs_rsp_rdy !== 1'b0) begin n_fail++; $display("FAIL prio_rsp_ready: got %b want 0", obs_rsp_rdy); end
        n_chk++; if (wr !== 1'b1 || wr_addr !== 4'd2 || wr_data !== 32'hA5A5_0002)
            begin n_fail++; $display("FAIL prio_alu_write: got %b/%h/%h want 1/2/a5a50002", wr, wr_addr, wr_data); end
        n_chk++; if (busy !== 16'h0200) begin n_fail++; $display("FAIL prio_busy: got %h want 0200", busy); end
        alu_vld = 0;
        cycle();
        n_chk++; if (obs_rsp_rdy !== 1'b1) begin n_fail++; $display("FAIL prio_rsp_ready2: got %b want 1", obs_rsp_rdy); end
        n_chk++; if (wr !== 1'b1 || wr_addr !== 4'd9 || wr_data !== 32'h99)
            begin n_fail++; $display("FAIL prio_ld_write: got %b/%h/%h want 1/9/99", wr, wr_addr, wr_data); end
        rsp_vld = 0;
        cycle();
    endtask

    task automatic test_full();
        req_vld = 1;
        for (int i = 1; i <= 4; i++) begin
            req_addr = 4'(i);
            cycle();
        end
        n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", req_rdy); end
        req_addr = 4'd5;
        cycle();
        n_chk++; if (busy !== 16'h001E) begin n_fail++; $display("FAIL full_fifth_ignored: busy got %h want 001e", busy); end
        // pop while still requesting: ready must not reflect the same-cycle pop
        req_addr = 4'd6; rsp_vld = 1; rsp_data = 32'h101;
        cycle();
        n_chk++; if (obs_req_rdy !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %b want 0", obs_req_rdy); end
        n_chk++; if (busy !== 16'h001C || req_rdy !== 1'b1)
            begin n_fail++; $display("FAIL full_pop: busy/ready got %h/%b want 001c/1", busy, req_rdy); end
        // push and pop at count 3
        rsp_data = 32'h102;
        cycle();
        n_chk++; if (wr_addr !== 4'd2 || busy !== 16'h0058 || req_rdy !== 1'b1)
            begin n_fail++; $display("FAIL full_pushpop: addr/busy/ready got %h/%h/%b want 2/0058/1", wr_addr, busy, req_rdy); end
        rsp_vld = 0; req_addr = 4'd8;
        cycle();
        n_chk++; if (req_rdy !== 1'b0 || busy !== 16'h0158)
            begin n_fail++; $display("FAIL full_refill: ready/busy got %b/%h want 0/0158", req_rdy, busy); end
        req_vld = 0; rsp_vld = 1;
        for (int i = 0; i < 4; i++) begin
            rsp_data = 32'h200 + 32'(i);
            cycle();
            n_chk++; if (wr !== exp_wr || wr_addr !== exp_addr || wr_data !== exp_data)
                begin n_fail++; $display("FAIL full_drain: got %b/%h/%h want %b/%h/%h", wr, wr_addr, wr_data, exp_wr, exp_addr, exp_data); end
        end
        rsp_vld = 0;
        cycle();
        n_chk++; if (busy !== 16'h0) begin n_fail++; $display("FAIL full_empty_busy: got %h want 0", busy); end
    endtask

    task automatic test_x0();
        alu_vld = 1; alu_addr = 4'd0; alu_data = 32'h1234;
        cycle();
        alu_vld = 0;
        n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL x0_alu: got %b want 0", wr); end
        req_vld = 1; req_addr = 4'd0;
        cycle();
        req_vld = 0;
        n_chk++; if (busy !== 16'h0001) begin n_fail++; $display("FAIL x0_busy_set: got %h want 0001", busy); end
        rsp_vld = 1; rsp_data = 32'h55;
        cycle();
        rsp_vld = 0;
        n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL x0_load: got %b want 0", wr); end
        n_chk++; if (busy !== 16'h0 || rsp_rdy !== 1'b0)
            begin n_fail++; $display("FAIL x0_popped: busy/rsp_ready got %h/%b want 0/0", busy, rsp_rdy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            alu_vld  = ($urandom_range(0, 3) == 0);
            alu_addr = 4'($urandom_range(0, 15));
            alu_data = $urandom;
            req_vld  = $urandom_range(0, 1);
            req_addr = 4'($urandom_range(0, 15));
            rsp_vld  = $urandom_range(0, 1);
            rsp_data = $urandom;
            cycle();
            n_chk++; if (obs_req_rdy !== exp_req_rdy || obs_rsp_rdy !== exp_rsp_rdy || obs_busy !== exp_busy)
                begin n_fail++; $display("FAIL rnd_handshake cyc %0d: rdy %b%b busy %h want %b%b %h", n, obs_req_rdy, obs_rsp_rdy, obs_busy, exp_req_rdy, exp_rsp_rdy, exp_busy); end
            n_chk++; if (wr !== exp_wr)
                begin n_fail++; $display("FAIL rnd_write cyc %0d: got %b want %b", n, wr, exp_wr); end
            if (exp_wr) begin
                n_chk++; if (wr_addr !== exp_addr || wr_data !== exp_data)
                    begin n_fail++; $display("FAIL rnd_payload cyc %0d: got %h/%h want %h/%h", n, wr_addr, wr_data, exp_addr, exp_data); end
            end
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_async_reset();
        rsp_vld = 1;
        repeat (LQ) cycle();
        rsp_vld = 0; req_vld = 1; req_addr = 4'd10;
        cycle();
        req_addr = 4'd11;
        cycle();
        req_vld = 0; alu_vld = 1; alu_addr = 4'd4; alu_data = 32'hCAFE_0004;
        cycle();
        alu_vld = 0;
        n_chk++; if (wr !== 1'b1 || busy !== 16'h0C00)
            begin n_fail++; $display("FAIL arst_pre: write/busy got %b/%h want 1/0c00", wr, busy); end
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (busy !== 16'h0 || req_rdy !== 1'b1 || wr !== 1'b0 || wr_data !== 32'h0)
            begin n_fail++; $display("FAIL arst_immediate: busy/ready/write/data got %h/%b/%b/%h want 0/1/0/0", busy, req_rdy, wr, wr_data); end
        q.delete();
        exp_wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rsp_vld = 1; rsp_data = 32'h77;
        cycle();
        rsp_vld = 0;
        n_chk++; if (obs_rsp_rdy !== 1'b0 || wr !== 1'b0)
            begin n_fail++; $display("FAIL arst_after_rsp: rsp_ready/write got %b/%b want 0/0", obs_rsp_rdy, wr); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_wr = 0; exp_addr = 0; exp_data = 0;
        test_reset();
        test_alu_write();
        test_load_order();
        test_alu_priority();
        test_full();
        test_x0();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
